// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-4 Booth multiplier family.
// Holds the FSM state type, the Booth digit codes and the digit-count helper.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    POS1 = 3'd1,
    POS2 = 3'd2,
    NEG1 = 3'd3,
    NEG2 = 3'd4
  } booth_digit_e;

  // Operands are extended by two bits, so WIDTH/2+1 digits cover every bit
  // of the extended multiplier, including the extension bits.
  function automatic int calc_iter(input int width);
    return width / 2 + 1;
  endfunction

endpackage

// File: rtl/booth_r4_enc.sv
// Radix-4 Booth recoder: maps a 3-bit multiplier window {b[2i+1], b[2i], b[2i-1]}
// to the multiple of the multiplicand that this digit contributes.
module booth_r4_enc
  import booth_pkg::*;
(
  input  logic [2:0]   win,
  output booth_digit_e digit
);

  always_comb begin
    digit = ZERO;
    case (win)
      3'b000, 3'b111: digit = ZERO;
      3'b001, 3'b010: digit = POS1;
      3'b011:         digit = POS2;
      3'b100:         digit = NEG2;
      3'b101, 3'b110: digit = NEG1;
      default:        digit = ZERO;
    endcase
  end

endmodule

// File: rtl/booth_mult_seq.sv
// Iterative radix-4 Booth multiplier: one Booth digit per cycle, signed or
// unsigned per transaction, product truncated to 2*WIDTH bits.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high. Upstream holds in_valid, x, y and is_signed stable until in_ready;
// p stays stable while out_valid is high and out_ready is low. in_ready and
// out_valid are never high together, so accept and deliver never share a cycle.
module booth_mult_seq
  import booth_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output state_e             dbg_state
);

  localparam int ITER = calc_iter(WIDTH);
  localparam int PW   = 2 * WIDTH;
  localparam int EW   = WIDTH + 2;
  localparam int CW   = $clog2(ITER + 1);
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
    $error("booth_mult_seq: WIDTH must be even and >= 4");
  end

  state_e       state, state_nxt;
  logic [PW-1:0] acc;
  logic [PW-1:0] mcand;      // extended multiplicand, pre-shifted by 2*count
  logic [EW-1:0] mplier;     // extended multiplier, consumed two bits per cycle
  logic          mplier_prev;
  logic [CW-1:0] count;

  logic [EW-1:0] xe, ye;
  logic [PW-1:0] pp, sum;
  booth_digit_e  digit;
  logic          accept, last;

  assign xe = {{2{is_signed & x[WIDTH-1]}}, x};
  assign ye = {{2{is_signed & y[WIDTH-1]}}, y};

  booth_r4_enc u_enc (
    .win   ({mplier[1], mplier[0], mplier_prev}),
    .digit (digit)
  );

  always_comb begin
    pp = '0;
    case (digit)
      ZERO:    pp = '0;
      POS1:    pp = mcand;
      POS2:    pp = {mcand[PW-2:0], 1'b0};
      NEG1:    pp = -mcand;
      NEG2:    pp = -{mcand[PW-2:0], 1'b0};
      default: pp = '0;
    endcase
  end

  // Wrap-around beyond PW bits is intended; the truncated sum is exact.
  assign sum    = acc + pp;
  assign last   = (count == LAST);
  assign accept = (state == IDLE) && in_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = BUSY;
      end
      BUSY: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc         <= '0;
      mcand       <= '0;
      mplier      <= '0;
      mplier_prev <= 1'b0;
      count       <= '0;
      p           <= '0;
    end else if (accept) begin
      acc         <= '0;
      mcand       <= {{(PW-EW){xe[EW-1]}}, xe};
      mplier      <= ye;
      mplier_prev <= 1'b0;
      count       <= '0;
    end else if (state == BUSY) begin
      acc         <= sum;
      mcand       <= {mcand[PW-3:0], 2'b00};
      mplier      <= {2'b00, mplier[EW-1:2]};
      mplier_prev <= mplier[1];
      count       <= count + 1'b1;
      if (last) p <= sum;
    end
  end

  assign dbg_state = state;

endmodule

// File: doc/booth_mult_seq.md
Name: booth_mult_seq

Overview:
- Iterative, parametrised radix-4 Booth multiplier with valid/ready handshakes on both sides.
- Supports signed and unsigned operands, selected per transaction.
- Consumes one Booth digit per cycle, trading area for latency against the existing fully combinational 16-bit multiplier.
- Serves as the shared multiply resource for the tanh datapath's polynomial/interpolation stages.

Parameters:
- WIDTH, 16, operand width in bits; must be even and >= 4 (elaboration-time check).
- ITER, WIDTH/2+1, number of Booth digits processed; derived, not overridable.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands and mode valid.
- in_ready  out  1  block can accept a transaction.
- x  in  WIDTH  multiplicand.
- y  in  WIDTH  multiplier.
- is_signed  in  1  1: x, y are two's complement; 0: x, y are unsigned.
- out_valid  out  1  p holds a completed product.
- out_ready  in  1  consumer accepts p.
- p  out  2*WIDTH  product, truncated to 2*WIDTH bits (exact for both modes).

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; in_ready=1; out_valid=0; p=0; internal accumulator, counter and operand registers cleared.
  - Reset asserted mid-transaction aborts that transaction; no product is emitted.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, register the extended operands and go to BUSY with count=0 and acc=0.
  - BUSY: in_ready=0. Each cycle adds partial product count into acc and increments count. When count==ITER-1, write the final sum to p and go to DONE.
  - DONE: out_valid=1; p stable. On out_valid&&out_ready, go to IDLE. in_ready stays 0 in DONE, so accept and deliver never occur in the same cycle.
- Latency and throughput:
  - Accept on edge k => out_valid high after edge k+ITER (WIDTH=16: 9 cycles).
  - Minimum initiation interval is ITER+2 cycles with out_ready held high.
- Operand extension: x and y are extended to WIDTH+2 bits, sign-extended if is_signed=1, else zero-extended. is_signed is sampled only at accept.
- Digit i (0..ITER-1):
  - Window {ye[2i+1], ye[2i], ye[2i-1]}, with ye[-1]=0.
  - Window to multiple of xe: 000/111 -> 0; 001/010 -> +1; 011 -> +2; 100 -> -2; 101/110 -> -1.
  - The partial product is sign-extended to 2*WIDTH bits, shifted left 2i, and added modulo 2^(2*WIDTH). Overflow beyond 2*WIDTH bits is discarded by design; the final result is exact.
- p updates only on the BUSY->DONE edge and holds until the next such edge, including through IDLE.
- in_valid, x, y and is_signed are ignored outside IDLE; the upstream block holds them until in_ready.
- out_ready is ignored unless in DONE.
- x/y changes during BUSY have no effect on the result.

Decomposition:
- Package booth_pkg:
  - state enum {IDLE, BUSY, DONE}.
  - Booth digit code type {ZERO, POS1, POS2, NEG1, NEG2}.
  - Function computing ITER from WIDTH.
- Sub-module booth_r4_enc: combinational; maps a 3-bit window to a digit code. Reused by the combinational multiplier's next revision.
- Datapath (extension, accumulator, counter) and FSM live in booth_mult_seq.

Test Plan:
- WIDTH=16, signed, x=0xFFFD (-3), y=0x0005 -> p=0xFFFFFFF1, out_valid exactly 9 cycles after accept edge.
- Unsigned x=0xFFFF, y=0xFFFF -> p=0xFFFE0001; same operands signed -> p=0x00000001.
- Signed x=0x8000, y=0x8000 -> p=0x40000000; signed x=0x7FFF, y=0x8000 -> p=0xC0008000.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid stays 1, p stable, in_ready=0; new in_valid with x=1, y=1 is not accepted until the cycle after the out handshake.
- Assert rst for 1 cycle during BUSY (count=4) -> in_ready=1, out_valid=0, p=0 immediately; next transaction 7*6 unsigned -> p=42 with normal latency.
- Random sweep: 10k random x, y, is_signed, random out_ready stalls, WIDTH in {4, 16, 32} -> p matches a reference model (signed or unsigned product mod 2^(2*WIDTH)).
